// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - PTE fields, MMIO offsets, fault causes and FSM states shared by mmu_bus
package mmu_pkg;

  localparam int PTE_V_BIT     = 15;
  localparam int PTE_W_BIT     = 14;
  localparam int PTE_FRAME_MSB = 7;

  localparam logic [5:0] OFF_PTE_BASE    = 6'h00;
  localparam logic [5:0] OFF_CTRL        = 6'h20;
  localparam logic [5:0] OFF_FAULT_VA    = 6'h22;
  localparam logic [5:0] OFF_FAULT_CAUSE = 6'h24;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_INVALID = 2'd1,
    CAUSE_WRITE   = 2'd2,
    CAUSE_ALIGN   = 2'd3
  } cause_t;

  typedef enum logic [1:0] {IDLE, ACCESS, FAULT} state_t;

  // Byte reads return the addressed lane zero-extended; word reads pass through.
  function automatic logic [15:0] lane_extract(input logic [15:0] word, input logic byte_access,
                                               input logic odd);
    if (!byte_access) return word;
    return odd ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/mmu_bus_if.sv
// rtl/mmu_bus_if.sv - core-side request/response bundle between the CPU core and mmu_bus
interface mmu_bus_if;
  logic [15:0] vaddr;
  logic [15:0] wdata;
  logic        re;
  logic        we;
  logic        be;
  logic [15:0] rdata;
  logic        stall;
  logic        page_fault;
  logic        fault_ack;

  modport master (output vaddr, wdata, re, we, be, fault_ack,
                  input  rdata, stall, page_fault);
  modport slave  (input  vaddr, wdata, re, we, be, fault_ack,
                  output rdata, stall, page_fault);
endinterface

// File: rtl/mmu_pagetable.sv
// rtl/mmu_pagetable.sv - 16x16 PTE register file: one MMIO write port, translation and MMIO read ports
module mmu_pagetable (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic [3:0]  tr_idx,
  output logic [15:0] tr_data,
  input  logic [3:0]  rd_idx,
  output logic [15:0] rd_data
);

  logic [15:0] pte [16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) pte[i] <= '0;
    end else if (wr_en) begin
      pte[wr_idx] <= wr_data;
    end
  end

  assign tr_data = pte[tr_idx];
  assign rd_data = pte[rd_idx];

endmodule

// File: rtl/mmu_bus.sv
// rtl/mmu_bus.sv - page-table MMU with MMIO register window driving a wait-stated SRAM
// Build option: define MMU_WRITE_PROTECT_EN to enforce the PTE W bit (fault cause 2).
module mmu_bus
  import mmu_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  mmu_bus_if.slave    bus,
  output logic [18:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_bwe
);

`ifdef MMU_WRITE_PROTECT_EN
  localparam bit WRITE_PROTECT = 1'b1;
`else
  localparam bit WRITE_PROTECT = 1'b0;
`endif

  state_t      state, state_nxt;
  cause_t      cause, fault_cause;
  logic [2:0]  wait_cnt;
  logic        done_q, ctrl_en, stall_c;
  logic [15:0] fault_va, rdata_q, mmio_word, pte_tr, pte_rd;
  logic [7:0]  frame;
  logic        page_valid, page_writable;
  logic        req, mmio_hit, sram_req, mmio_wr, pt_wr;
  logic [5:1]  mmio_off;
  logic        unused_pte;

  assign req      = bus.re | bus.we;
  assign mmio_off = bus.vaddr[5:1];
  assign mmio_hit = (bus.vaddr[15:6] == MMIO_BASE[15:6]);
  // The cycle after an access completes the core still holds the old request.
  assign sram_req = req & ~mmio_hit & ~done_q;
  assign mmio_wr  = bus.we & mmio_hit;
  assign pt_wr    = mmio_wr & (mmio_off[5] == OFF_PTE_BASE[5]);

  mmu_pagetable u_pagetable (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pt_wr),
    .wr_idx  (mmio_off[4:1]),
    .wr_data (bus.wdata),
    .tr_idx  (bus.vaddr[15:12]),
    .tr_data (pte_tr),
    .rd_idx  (mmio_off[4:1]),
    .rd_data (pte_rd)
  );

  assign unused_pte    = ^pte_tr[13:8];
  assign frame         = ctrl_en ? pte_tr[PTE_FRAME_MSB:0] : {4'b0, bus.vaddr[15:12]};
  assign page_valid    = ~ctrl_en | pte_tr[PTE_V_BIT];
  assign page_writable = ~ctrl_en | pte_tr[PTE_W_BIT];

  always_comb begin
    cause = CAUSE_NONE;
    if (!page_valid)                                   cause = CAUSE_INVALID;
    else if (WRITE_PROTECT && bus.we && !page_writable) cause = CAUSE_WRITE;
    else if (!bus.be && bus.vaddr[0])                   cause = CAUSE_ALIGN;
  end

  always_comb begin
    mmio_word = '0;
    if (mmio_off[5] == OFF_PTE_BASE[5])         mmio_word = pte_rd;
    else if (mmio_off == OFF_CTRL[5:1])        mmio_word = {15'd0, ctrl_en};
    else if (mmio_off == OFF_FAULT_VA[5:1])    mmio_word = fault_va;
    else if (mmio_off == OFF_FAULT_CAUSE[5:1]) mmio_word = {14'd0, fault_cause};
  end

  assign bus.rdata      = (bus.re & mmio_hit) ? lane_extract(mmio_word, bus.be, bus.vaddr[0]) : rdata_q;
  assign bus.stall      = stall_c & reset;
  assign bus.page_fault = (state == FAULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (sram_req) begin
          stall_c   = 1'b1;
          state_nxt = (cause != CAUSE_NONE) ? FAULT : ACCESS;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (wait_cnt == 3'd0) state_nxt = IDLE;
      end
      FAULT: begin
        if (bus.fault_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_bwe   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done_q <= (state == ACCESS) && (state_nxt == IDLE);
      if (state == IDLE)
        wait_cnt <= 3'(WAIT_STATES);
      else if (state == ACCESS && wait_cnt != 3'd0)
        wait_cnt <= wait_cnt - 3'd1;
      if (state == ACCESS && wait_cnt == 3'd0 && bus.re)
        rdata_q <= lane_extract(mem_rdata, bus.be, bus.vaddr[0]);
      mem_en    <= (state_nxt == ACCESS);
      mem_we    <= (state_nxt == ACCESS) && bus.we;
      mem_addr  <= (state_nxt == ACCESS) ? {frame, bus.vaddr[11:1]} : '0;
      mem_bwe   <= ((state_nxt == ACCESS) && bus.we) ?
                   (bus.be ? (bus.vaddr[0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
      mem_wdata <= ((state_nxt == ACCESS) && bus.we) ?
                   (bus.be ? {2{bus.wdata[7:0]}} : bus.wdata) : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en     <= 1'b0;
      fault_va    <= '0;
      fault_cause <= CAUSE_NONE;
    end else begin
      if (mmio_wr && mmio_off == OFF_CTRL[5:1]) ctrl_en <= bus.wdata[0];
      if (state == IDLE && state_nxt == FAULT) begin
        fault_va    <= bus.vaddr;
        fault_cause <= cause;
      end
    end
  end

endmodule

// File: tb/tb_mmu_bus.sv
// tb/tb_mmu_bus.sv - scoreboard bench for mmu_bus against a byte-addressed reference model
module tb_mmu_bus;

  localparam int unsigned WS   = 1;
  localparam logic [15:0] MMIO = 16'hFF00;
  localparam int K_SRAM = 0, K_FAULT = 1, K_MMIO = 2;

  typedef struct {
    int          kind;
    logic [18:0] addr;
    logic        we;
    logic [1:0]  bwe;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [1:0]  mem_bwe;

  mmu_bus_if bus();

  mmu_bus #(.WAIT_STATES(WS), .MMIO_BASE(MMIO)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_bwe   (mem_bwe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  // Reference model state
  logic [15:0] m_pte [16];
  logic        m_ctrl;
  logic [15:0] m_fva;
  logic [1:0]  m_fcause;
  logic [7:0]  ref_mem [int];

  // SRAM behavioural model
  logic [15:0] sram [0:(1<<19)-1];
  assign mem_rdata = sram[mem_addr];

  initial begin
    for (int i = 0; i < (1 << 19); i++) sram[i] = 16'h0000;
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) begin
        if (mem_bwe[0]) sram[mem_addr][7:0]  = mem_wdata[7:0];
        if (mem_bwe[1]) sram[mem_addr][15:8] = mem_wdata[15:8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mmio(input logic [15:0] va);
    return va[15:6] == MMIO[15:6];
  endfunction

  function automatic logic [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pte[i] = 16'h0000;
    m_ctrl   = 1'b0;
    m_fva    = 16'h0000;
    m_fcause = 2'd0;
  endtask

  task automatic predict(input logic [15:0] va, input logic [15:0] wd, input logic wr,
                         input logic byt, output exp_t e, output int c);
    int page, frame, w, b;
    logic valid;
`ifdef MMU_WRITE_PROTECT_EN
    logic wrt;
`endif
    page  = int'(va[15:12]);
    valid = !m_ctrl || m_pte[page][15];
    frame = m_ctrl ? int'(m_pte[page][7:0]) : page;
`ifdef MMU_WRITE_PROTECT_EN
    wrt   = !m_ctrl || m_pte[page][14];
`endif
    c = 0;
    if (!valid) c = 1;
`ifdef MMU_WRITE_PROTECT_EN
    else if (wr && !wrt) c = 2;
`endif
    else if (!byt && va[0]) c = 3;
    w = frame * 2048 + int'(va[11:0]) / 2;
    b = 2 * w + int'(va[0]);
    e = '{kind: K_SRAM, addr: 19'(w), we: wr, bwe: 2'b00, wdata: 16'h0, rdata: 16'h0};
    if (c != 0) begin
      e.kind   = K_FAULT;
      m_fva    = va;
      m_fcause = 2'(c);
    end else if (wr) begin
      e.bwe   = byt ? (va[0] ? 2'b10 : 2'b01) : 2'b11;
      e.wdata = byt ? {wd[7:0], wd[7:0]} : wd;
      if (byt) ref_mem[b] = wd[7:0];
      else begin
        ref_mem[2*w]   = wd[7:0];
        ref_mem[2*w+1] = wd[15:8];
      end
    end else begin
      e.rdata = byt ? {8'h00, ref_byte(b)} : {ref_byte(2*w+1), ref_byte(2*w)};
    end
  endtask

  task automatic mmio_write(input logic [5:0] off, input logic [15:0] d);
    bus.vaddr = MMIO | {10'd0, off};
    bus.wdata = d;
    bus.be    = 1'b0;
    bus.we    = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
    if (off < 6'h20) m_pte[off[4:1]] = d;
    else if (off == 6'h20) m_ctrl = d[0];
  endtask

  task automatic mmio_read(input logic [5:0] off);
    exp_t e;
    e = '{kind: K_MMIO, addr: 19'h0, we: 1'b0, bwe: 2'b00, wdata: 16'h0, rdata: 16'h0};
    if (off < 6'h20)        e.rdata = m_pte[off[4:1]];
    else if (off == 6'h20)  e.rdata = {15'd0, m_ctrl};
    else if (off == 6'h22)  e.rdata = m_fva;
    else if (off == 6'h24)  e.rdata = {14'd0, m_fcause};
    sb.push_back(e);
    bus.vaddr = MMIO | {10'd0, off};
    bus.be    = 1'b0;
    bus.re    = 1'b1;
    @(posedge clk); #1;
    bus.re = 1'b0;
  endtask

  task automatic access(input logic [15:0] va, input logic [15:0] wd, input logic wr, input logic byt);
    int c, n;
    exp_t e;
    predict(va, wd, wr, byt, e, c);
    sb.push_back(e);
    bus.vaddr = va;
    bus.wdata = wd;
    bus.be    = byt;
    bus.we    = wr;
    bus.re    = !wr;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (bus.stall) check("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.re = 1'b0;
    bus.we = 1'b0;
    if (c != 0) begin
      @(negedge clk); check("page_fault_held", 32'(bus.page_fault), 32'd1);
      @(posedge clk); #1; bus.fault_ack = 1'b1;
      @(negedge clk); check("page_fault_until_ack", 32'(bus.page_fault), 32'd1);
      @(posedge clk); #1; bus.fault_ack = 1'b0;
      @(negedge clk); check("page_fault_cleared", 32'(bus.page_fault), 32'd0);
      @(posedge clk); #1;
      mmio_read(6'h22);
      mmio_read(6'h24);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an SRAM access, a fault or MMIO read data
  initial begin
    int   stall_cnt;
    bit   pend;
    exp_t cur;
    logic prev_en, prev_pf, prev_stall;
    stall_cnt = 0; pend = 0; prev_en = 0; prev_pf = 0; prev_stall = 0;
    cur = '{kind: K_SRAM, addr: 19'h0, we: 1'b0, bwe: 2'b00, wdata: 16'h0, rdata: 16'h0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_cnt = 0; pend = 0; prev_en = 0; prev_pf = 0; prev_stall = 0;
      end else begin
        if (mem_en && !prev_en) begin
          if (sb.size() == 0 || sb[0].kind != K_SRAM) check("unexpected_sram_access", 32'd1, 32'd0);
          else begin
            cur  = sb.pop_front();
            pend = 1;
            check("mem_addr", 32'(mem_addr), 32'(cur.addr));
            check("mem_we", 32'(mem_we), 32'(cur.we));
            if (cur.we) begin
              check("mem_bwe", 32'(mem_bwe), 32'(cur.bwe));
              check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
            end
          end
        end
        if (bus.page_fault && !prev_pf) begin
          if (sb.size() == 0 || sb[0].kind != K_FAULT) check("unexpected_fault", 32'd1, 32'd0);
          else void'(sb.pop_front());
        end
        if (bus.re && is_mmio(bus.vaddr)) begin
          if (sb.size() == 0 || sb[0].kind != K_MMIO) check("unexpected_mmio_read", 32'd1, 32'd0);
          else begin
            cur = sb.pop_front();
            check("mmio_rdata", 32'(bus.rdata), 32'(cur.rdata));
            check("mmio_stall", 32'(bus.stall), 32'd0);
          end
        end
        if (bus.stall) stall_cnt++;
        else if (prev_stall) begin
          if (pend) begin
            check("sram_stall_cycles", stall_cnt, WS + 2);
            if (!cur.we) check("sram_rdata", 32'(bus.rdata), 32'(cur.rdata));
            pend = 0;
          end else begin
            check("fault_stall_cycles", stall_cnt, 1);
            check("page_fault_at_stall_drop", 32'(bus.page_fault), 32'd1);
          end
          stall_cnt = 0;
        end
        prev_en    = mem_en;
        prev_pf    = bus.page_fault;
        prev_stall = bus.stall;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_quiet(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_bwe"}, 32'(mem_bwe), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check({tag, "_page_fault"}, 32'(bus.page_fault), 32'd0);
    check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] va;
    bus.vaddr = 16'h0; bus.wdata = 16'h0; bus.re = 1'b0; bus.we = 1'b0;
    bus.be = 1'b0; bus.fault_ack = 1'b0;
    model_reset();
    #1;
    check_quiet("reset0");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mmio_read(6'h20);
    mmio_read(6'h22);
    mmio_read(6'h24);

    // Identity mapping, misalignment, byte lanes
    access(16'h1234, 16'hBEEF, 1'b1, 1'b0);
    access(16'h1234, 16'h0000, 1'b0, 1'b0);
    access(16'h0003, 16'h0000, 1'b0, 1'b0);
    access(16'h0001, 16'h00AB, 1'b1, 1'b1);
    access(16'h0000, 16'hAB12, 1'b1, 1'b0);
    access(16'h0001, 16'h0000, 1'b0, 1'b1);
    access(16'h0000, 16'h0000, 1'b0, 1'b1);

    // Translation, write to read-only page, invalid page
    mmio_write(6'h02, 16'h8042);
    mmio_write(6'h20, 16'h0001);
    access(16'h1006, 16'h5A5A, 1'b1, 1'b0);
    access(16'h1006, 16'h0000, 1'b0, 1'b0);
    access(16'h5000, 16'h0000, 1'b0, 1'b0);
    mmio_read(6'h02);
    mmio_read(6'h20);

    // Randomized page tables and accesses
    for (int batch = 0; batch < 5; batch++) begin
      for (int p = 0; p < 4; p++) begin
        v = {($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 6'd0, 8'($urandom_range(0, 7))};
        mmio_write(6'(2 * p), v);
      end
      mmio_write(6'h20, 16'($urandom_range(0, 1)));
      mmio_read(6'(2 * $urandom_range(0, 3)));
      for (int k = 0; k < 16; k++) begin
        va = 16'(($urandom_range(0, 3) << 12) | $urandom_range(0, 15));
        access(va, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Reset in the second ACCESS cycle of a read
    mmio_write(6'h04, 16'hC005);
    mmio_write(6'h20, 16'h0001);
    bus.vaddr = 16'h2010; bus.be = 1'b0; bus.re = 1'b1;
    begin
      exp_t e;
      int c;
      predict(16'h2010, 16'h0000, 1'b0, 1'b0, e, c);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.re = 1'b0;
    #1;
    check_quiet("reset_mid");
    model_reset();
    check("scoreboard_empty_at_reset", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("after_release");
    @(posedge clk); #1;
    mmio_read(6'h20);
    for (int p = 0; p < 4; p++) mmio_read(6'(2 * p));
    mmio_read(6'h22);
    mmio_read(6'h24);
    access(16'h3002, 16'h1357, 1'b1, 1'b0);
    access(16'h3002, 16'h0000, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_bus.md
# mmu_bus

Memory-side stage directly downstream of the CPU core. It takes the core's virtual byte address, write data, `we`, `re` and `be` and translates the address through a 16-entry page table. It then drives a wait-stated external SRAM and returns read data to the core. Invalid or illegal accesses raise `page_fault` into the core's trap encoder, and the translating address is latched for the handler.

## Interface
- `WAIT_STATES`, 1, extra SRAM cycles per access (0–7)
- `MMIO_BASE`, 16'hFF00, base of the MMU register window (64 bytes)
- `clk` in 1: single clock, all state on posedge
- `reset` in 1: asynchronous, active-low
- `vaddr` in 16: core virtual byte address
- `wdata` in 16: core write data
- `re`, `we` in 1: core read and write request; mutually exclusive, held until `stall` is low
- `be` in 1: 1 = byte access, lane = `vaddr[0]`
- `rdata` out 16: read data; byte reads are zero-extended
- `stall` out 1: core must hold the request
- `page_fault` out 1: trap request
- `fault_ack` in 1: trap taken
- `mem_addr` out 19: SRAM word address {frame[7:0], vaddr[11:1]}
- `mem_wdata` out 16, `mem_rdata` in 16: SRAM data
- `mem_en`, `mem_we` out 1, `mem_bwe` out 2: SRAM strobes and byte-write enables

## Operation
- **Page table.** 16 PTEs, indexed by `vaddr[15:12]`. PTE bit15 = V (valid), bit14 = W (writable), [7:0] = frame.
- **MMIO window.** Addresses `MMIO_BASE`+0x00..0x1E are the PTEs. +0x20 is CTRL (bit0 = translation enable). +0x22 is FAULT_VA (read-only). +0x24 is FAULT_CAUSE (read-only).
- **MMIO access.** Never translated, never faults, never reaches the SRAM.
- **Translation off.** frame = {4'b0, `vaddr[15:12]`}. All pages are treated as valid and writable.
- **Fault causes.**
  - 1: V = 0.
  - 2: write to a page with W = 0.
  - 3: word access with `vaddr[0]` = 1.
- **Lanes.** Lane 0 = bits [7:0] at even addresses.
  - Byte write: `mem_wdata` = {wdata[7:0], wdata[7:0]}; `mem_bwe` = `vaddr[0]` ? 2'b10 : 2'b01.
  - Word write: `mem_bwe` = 2'b11.
- **FSM.**
  - IDLE → on `re`|`we` to a non-MMIO address: if a fault is detected go to FAULT, else go to ACCESS.
  - ACCESS: a counter loads `WAIT_STATES`, decrements each cycle, and returns to IDLE when it reaches 0 with `rdata` captured.
  - FAULT: hold `page_fault` until `fault_ack`, then go to IDLE.
- **Fault recording.** On entry to FAULT, FAULT_VA ← `vaddr` and FAULT_CAUSE ← cause. No SRAM strobe is issued.
- **Simultaneous events.** `fault_ack` has no effect outside FAULT. A PTE write takes effect for requests arriving the next cycle.

## Timing
- **Reset values.** All outputs 0 except `stall` (0). CTRL = 0, all PTEs = 0, FAULT_VA = 0, FAULT_CAUSE = 0. FSM returns to IDLE immediately.
- **Reset mid-access.** The access is abandoned and no write completes after `reset` falls.
- **MMIO.** Zero stall. Writes commit at the request edge; reads return combinationally.
- **SRAM request stall.** `stall` is combinational high from the first request cycle through the last ACCESS cycle. The core sees `rdata` valid in the cycle `stall` falls. Total latency is `WAIT_STATES`+2 cycles.
- **SRAM strobes.** `mem_en`/`mem_we`/`mem_bwe`/`mem_addr` are registered and asserted for every ACCESS cycle.
- **Fault timing.** `stall` is high in the detection cycle. `page_fault` rises the next cycle, when `stall` drops. It falls the cycle after `fault_ack` is sampled.

## Configuration
- `MMU_WRITE_PROTECT_EN` defined: the W bit is enforced and cause 2 is raised.
- Not defined: W is stored and read back but ignored, and cause 2 never occurs.

## Structure
- **Package `mmu_pkg`.**
  - PTE bit positions.
  - MMIO offsets (PTE, CTRL, FAULT_VA, FAULT_CAUSE).
  - Cause codes.
  - FSM state enum {IDLE, ACCESS, FAULT}.
- **Sub-module `mmu_pagetable`.** 16×16 register file with one MMIO write port, one translation read port and one MMIO read port. It has async reset to 0.

## Test plan
- **Identity mapping.** CTRL = 0, `WAIT_STATES` = 1, word write 0xBEEF to 0x1234, then read it back. Expected: `mem_addr` = 0x0091A, `mem_bwe` = 11, `stall` high 3 cycles, read returns 0xBEEF.
- **Translation.** PTE1 = 0x8042 (V, no W), CTRL = 1. Reading 0x1006 drives `mem_addr` = {0x42, 0x003}. A write to 0x1006 raises `page_fault` with FAULT_CAUSE = 2, FAULT_VA = 0x1006 and no `mem_we`.
- **Invalid and misaligned.** A read at 0x5000 with PTE5 = 0 gives cause 1. A word read at 0x0003 gives cause 3. `page_fault` stays high until `fault_ack`, then falls one cycle later.
- **Byte lanes.** Byte write 0xAB to 0x0001 gives `mem_bwe` = 10 and `mem_wdata` = 0xABAB. A byte read of 0x0001 from SRAM word 0xAB12 returns 0x00AB.
- **Reset.** Assert `reset` low in the 2nd ACCESS cycle. Outputs go to 0 asynchronously, the FSM is in IDLE after release, and CTRL and all PTEs read 0.
- **Write-protect disabled.** Build without `MMU_WRITE_PROTECT_EN` and repeat the translation write. Expected: no fault, and `mem_we` is asserted.
